// File: rtl/spi_bitrev_pkg.sv
// spi_bitrev_pkg: shared FSM encoding and SPI mode constants for spi_bitrev_slave
package spi_bitrev_pkg;
    typedef enum logic [1:0] {IDLE, RX, TX, DONE} state_e;
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RX   = RX;
    localparam logic [1:0] ST_TX   = TX;
    localparam logic [1:0] ST_DONE = DONE;
    // {CPOL,CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;
endpackage

// File: rtl/spi_bitrev_slave_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser with rise/fall pulse outputs
//   clock, reset_n : system clock, async active-low reset
//   d              : asynchronous input
//   q              : synchronised level
//   rise, fall     : 1-clock pulses on synchronised transitions
module spi_sync_edge
    import spi_bitrev_pkg::*;
#(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync;
    logic              prev;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync <= {STAGES{INIT}};
            prev <= INIT;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            prev <= sync[STAGES-1];
        end
    end
    assign q    = sync[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;
endmodule

// File: rtl/spi_bitrev_slave.sv
// spi_bitrev_slave: system-clocked SPI slave that returns each received word bit-reversed or echoed
//   clock, reset_n : system clock, async active-low reset
//   sck, ss, mosi  : SPI pins from master (asynchronous, ss active-low)
//   miso, miso_oe  : slave data out (1 when idle) and output enable (synced ss low)
//   rx_data        : last completely received word; rx_valid pulses on update
//   done           : pulses when a full 2*WIDTH-bit frame completes
//   abort          : only with SPI_BITREV_ABORT_EN; pulses when ss rises mid RX/TX,
//                    counted in saturating abort_cnt
module spi_bitrev_slave
    import spi_bitrev_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2,
    parameter int REVERSE     = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             sck,
    input  logic             ss,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
`ifdef SPI_BITREV_ABORT_EN
    output logic             abort,
`endif
    output logic             done
);
    localparam int             CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
    logic                   sck_q, sck_rise, sck_fall;
    logic                   ss_q, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   lead, trail, sample, shift;
    logic [1:0]             state;
    logic [CW-1:0]          cnt;
    logic [WIDTH-1:0]       rx_sr, tx_sr, rx_next, rx_rev, tx_load;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'(CPOL))) u_sck (
        .clock(clock), .reset_n(reset_n), .d(sck), .q(sck_q), .rise(sck_rise), .fall(sck_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ss (
        .clock(clock), .reset_n(reset_n), .d(ss), .q(ss_q), .rise(ss_rise), .fall(ss_fall)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            mosi_sync <= '0;
        else
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end

    always_comb begin
        lead    = (CPOL != 0) ? sck_fall : sck_rise;
        trail   = (CPOL != 0) ? sck_rise : sck_fall;
        sample  = (CPHA != 0) ? trail : lead;
        shift   = (CPHA != 0) ? lead : trail;
        rx_next = {rx_sr[WIDTH-2:0], mosi_sync[SYNC_STAGES-1]};
        tx_load = (REVERSE != 0) ? rx_next : rx_rev;
    end

    // rx_next holds the first-arrived bit at the MSB; tx_sr always shifts out from bit 0
    genvar i;
    for (i = 0; i < WIDTH; i++) begin : g_rev
        assign rx_rev[i] = rx_next[WIDTH-1-i];
    end

    assign miso_oe = ~ss_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rx_sr    <= '0;
            tx_sr    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            done     <= 1'b0;
            miso     <= 1'b1;
        end else begin
            rx_valid <= 1'b0;
            done     <= 1'b0;
            // ss release outranks any sck edge seen in the same clock
            if (ss_rise) begin
                state <= ST_IDLE;
                miso  <= 1'b1;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        miso <= 1'b1;
                        if (ss_fall) begin
                            cnt   <= '0;
                            rx_sr <= '0;
                            state <= ST_RX;
                        end
                    end
                    ST_RX: begin
                        if (sample) begin
                            rx_sr <= rx_next;
                            if (cnt == LAST) begin
                                rx_data  <= rx_next;
                                rx_valid <= 1'b1;
                                tx_sr    <= tx_load;
                                state    <= ST_TX;
                                cnt      <= '0;
                            end else
                                cnt <= cnt + 1'b1;
                        end
                    end
                    ST_TX: begin
                        if (shift) begin
                            miso  <= tx_sr[0];
                            tx_sr <= tx_sr >> 1;
                        end
                        if (sample) begin
                            if (cnt == LAST) begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end else
                                cnt <= cnt + 1'b1;
                        end
                    end
                    ST_DONE: miso <= 1'b1;
                    default: begin
                        state <= ST_IDLE;
                        miso  <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef SPI_BITREV_ABORT_EN
    logic [7:0] abort_cnt;
    logic       aborting;
    assign aborting = ss_rise && (state == ST_RX || state == ST_TX);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            abort     <= 1'b0;
            abort_cnt <= '0;
        end else begin
            abort <= aborting;
            if (aborting && abort_cnt != 8'hFF)
                abort_cnt <= abort_cnt + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_spi_bitrev_slave.sv
// tb_spi_bitrev_slave: scoreboard bench driving six slave configurations from one SPI master
module tb_spi_bitrev_slave;
    import spi_bitrev_pkg::*;
    localparam int         N  = 6;
    localparam int         HP = 5;
    localparam int         S  = 2;
    localparam int         WID [N] = '{8, 8, 8, 8, 8, 16};
    localparam logic [1:0] MODE[N] = '{MODE0, MODE0, MODE1, MODE2, MODE3, MODE0};
    localparam int         REV [N] = '{1, 0, 1, 1, 1, 1};

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         sck_m = 1'b0;
    logic         mosi = 1'b0;
    logic [N-1:0] ss_v = '1;
    logic [N-1:0] miso_v, oe_v, rxv_v, done_v;
    logic [15:0]  rx_all [N];
`ifdef SPI_BITREV_ABORT_EN
    logic [N-1:0] abort_v;
    int           abort_seen = 0;
`endif
    int           cur = 0;
    int           checks = 0;
    int           errors = 0;
    int           rxv_cnt = 0;
    int           done_cnt = 0;
    logic [15:0]  exp_rx[$];
    logic [15:0]  exp_tx[$];
    logic [15:0]  word;

    always #5 clock = ~clock;

    // CPOL=1 slaves see the inverted master clock, so a rising sck_m is always the lead edge
    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [WID[g]-1:0] rxd;
        spi_bitrev_slave #(
            .WIDTH(WID[g]), .CPOL(int'(MODE[g][1])), .CPHA(int'(MODE[g][0])),
            .SYNC_STAGES(S), .REVERSE(REV[g])
        ) u (
            .clock(clock),
            .reset_n(reset_n),
            .sck(MODE[g][1] ? ~sck_m : sck_m),
            .ss(ss_v[g]),
            .mosi(mosi),
            .miso(miso_v[g]),
            .miso_oe(oe_v[g]),
            .rx_data(rxd),
            .rx_valid(rxv_v[g]),
`ifdef SPI_BITREV_ABORT_EN
            .abort(abort_v[g]),
`endif
            .done(done_v[g])
        );
        assign rx_all[g] = 16'(rxd);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (rxv_v[cur]) begin
            rxv_cnt++;
            check("rx_expected", 32'(exp_rx.size() != 0), 1);
            if (exp_rx.size() != 0)
                check("rx_data", 32'(rx_all[cur]), 32'(exp_rx.pop_front()));
        end
        if (done_v[cur])
            done_cnt++;
`ifdef SPI_BITREV_ABORT_EN
        if (abort_v[cur])
            abort_seen++;
`endif
    end

    task automatic half();
        repeat (HP) @(negedge clock);
    endtask

    // Drops ss and runs nbits bit periods MSB-first; ss is left low
    task automatic xfer(input int idx, input logic [15:0] d, input int nbits,
                        input logic [15:0] tx_exp, output logic [15:0] r);
        int w;
        bit ph;
        w = WID[idx];
        ph = MODE[idx][0];
        r = '0;
        cur = idx;
        rxv_cnt = 0;
        done_cnt = 0;
        if (nbits >= w) exp_rx.push_back(d);
        if (nbits == 2 * w) exp_tx.push_back(tx_exp);
        @(negedge clock);
        ss_v[idx] = 1'b0;
        half();
        for (int b = 0; b < nbits; b++) begin
            if (!ph) mosi = (b < w) ? d[w-1-b] : 1'b0;
            half();
            sck_m = 1'b1;
            if (ph) mosi = (b < w) ? d[w-1-b] : 1'b0;
            else if (b >= w) r = {r[14:0], miso_v[idx]};
            half();
            sck_m = 1'b0;
            if (ph && b >= w) r = {r[14:0], miso_v[idx]};
        end
        half();
        if (nbits == 2 * w)
            check("tx_word", 32'(r), 32'(exp_tx.pop_front()));
    endtask

    task automatic ss_up(input int idx);
        @(negedge clock);
        ss_v[idx] = 1'b1;
        repeat (S + 3) @(negedge clock);
        check("idle_miso", 32'(miso_v[idx]), 1);
        check("idle_oe", 32'(oe_v[idx]), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (4) @(negedge clock);
        for (int i = 0; i < N; i++) begin
            check("rst_miso", 32'(miso_v[i]), 1);
            check("rst_oe", 32'(oe_v[i]), 0);
            check("rst_rx", 32'(rx_all[i]), 0);
            check("rst_rxv", 32'(rxv_v[i]), 0);
            check("rst_done", 32'(done_v[i]), 0);
        end
        reset_n = 1'b1;
        repeat (4) @(negedge clock);

        xfer(0, 16'hD2, 16, 16'h4B, word);
        check("oe_active", 32'(oe_v[0]), 1);
        check("m0_rxv_cnt", rxv_cnt, 1);
        check("m0_done_cnt", done_cnt, 1);
        for (int e = 0; e < 4; e++) begin
            half();
            sck_m = ~sck_m;
            half();
            check("post_done_miso", 32'(miso_v[0]), 1);
        end
        check("post_done_rxv", rxv_cnt, 1);
        check("post_done_done", done_cnt, 1);
        ss_up(0);

        xfer(1, 16'hD2, 16, 16'hD2, word);
        check("echo_rxv_cnt", rxv_cnt, 1);
        check("echo_done_cnt", done_cnt, 1);
        ss_up(1);

        for (int m = 2; m <= 4; m++) begin
            xfer(m, 16'hD2, 16, 16'h4B, word);
            check("mode_rxv_cnt", rxv_cnt, 1);
            check("mode_done_cnt", done_cnt, 1);
            ss_up(m);
        end

        xfer(5, 16'h8001, 32, 16'h8001, word);
        check("w16a_rxv_cnt", rxv_cnt, 1);
        ss_up(5);
        xfer(5, 16'h00F0, 32, 16'h0F00, word);
        check("w16b_rxv_cnt", rxv_cnt, 1);
        check("w16b_done_cnt", done_cnt, 1);
        ss_up(5);

`ifdef SPI_BITREV_ABORT_EN
        abort_seen = 0;
`endif
        xfer(0, 16'h5A, 5, 16'h0, word);
        ss_up(0);
        check("abort_rxv", rxv_cnt, 0);
        check("abort_done", done_cnt, 0);
        check("abort_rx_kept", 32'(rx_all[0]), 32'hD2);
`ifdef SPI_BITREV_ABORT_EN
        check("abort_pulse", abort_seen, 1);
        check("abort_cnt", 32'(g_dut[0].u.abort_cnt), 1);
`endif

        xfer(0, 16'hA5, 11, 16'h0, word);
        check("pre_rst_miso", 32'(miso_v[0]), 0);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_miso", 32'(miso_v[0]), 1);
        check("mid_rst_done", 32'(done_v[0]), 0);
        check("mid_rst_oe", 32'(oe_v[0]), 0);
        check("mid_rst_rx", 32'(rx_all[0]), 0);
        ss_v[0] = 1'b1;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (S + 3) @(negedge clock);
        xfer(0, 16'h01, 16, 16'h80, word);
        check("after_rst_rxv", rxv_cnt, 1);
        check("after_rst_done", done_cnt, 1);
        ss_up(0);

        check("rx_queue_drained", exp_rx.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
